// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared FSM state encodings for the pipeline hazard controller
package hazard_ctrl_pkg;
  localparam int HAZ_ST_W = 2;
  localparam logic [1:0] HAZ_ST_RUN = 2'd0;
  localparam logic [1:0] HAZ_ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] HAZ_ST_FLUSH = 2'd2;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  // count up, holding at all-ones
  always_ff @(posedge clk)
    count <= clr ? '0 : (inc & ~&count) ? count + 1'b1 : count;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/clear/redirect control for the five-stage pipeline; perf counters built when HAZ_PERF_CNT_EN is defined
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                i_id_mem_hazard,
  input  logic                i_ex_branch_taken,
  input  logic                i_me_req,
  input  logic                i_me_ack,
  output logic                o_if_stall,
  output logic                o_id_stall,
  output logic                o_ex_stall,
  output logic                o_me_stall,
  output logic                o_id_clr,
  output logic                o_ex_clr,
  output logic                o_pc_redirect,
  output logic                o_mem_timeout,
  output logic [HAZ_ST_W-1:0] o_state,
  output logic [CNT_W-1:0]    o_cnt_load,
  output logic [CNT_W-1:0]    o_cnt_flush,
  output logic [CNT_W-1:0]    o_cnt_mem
);
  logic [HAZ_ST_W-1:0] state, state_n;
  logic [3:0] flush_cnt, flush_cnt_n;
  logic [15:0] wait_cnt, wait_inc;
  logic busy, resume, br, ld, fl, stall_all;
  assign busy      = i_me_req & ~i_me_ack;
  // a wait that interrupted a flush resumes it once the access completes
  assign resume    = (state == HAZ_ST_MEM_WAIT) & (flush_cnt != 4'd0);
  assign stall_all = ~clr & busy;
  assign br        = ~clr & ~busy & i_ex_branch_taken;
  assign fl        = ~clr & ~busy & ~br & (state == HAZ_ST_FLUSH);
  assign ld        = ~clr & ~busy & ~br & ~fl & ~resume & i_id_mem_hazard;
  assign wait_inc  = (&wait_cnt) ? wait_cnt : wait_cnt + 16'd1;
  assign o_if_stall    = stall_all | ld;
  assign o_id_stall    = stall_all | ld;
  assign o_ex_stall    = stall_all;
  assign o_me_stall    = stall_all;
  assign o_id_clr      = clr | br | fl;
  assign o_ex_clr      = clr | br | ld;
  assign o_pc_redirect = br;
  assign o_state       = state;
  // next state and flush countdown, priority clr > busy > branch > flush/load-use
  always_comb begin
    state_n = clr ? HAZ_ST_RUN :
              busy ? HAZ_ST_MEM_WAIT :
              br ? ((FLUSH_CYCLES > 0) ? HAZ_ST_FLUSH : HAZ_ST_RUN) :
              fl ? ((flush_cnt <= 4'd1) ? HAZ_ST_RUN : HAZ_ST_FLUSH) :
              resume ? HAZ_ST_FLUSH : HAZ_ST_RUN;
    flush_cnt_n = clr ? 4'd0 :
                  busy ? flush_cnt :
                  br ? 4'(FLUSH_CYCLES) :
                  fl ? flush_cnt - 4'd1 : flush_cnt;
  end
  // state, counters and sticky timeout
  always_ff @(posedge clk) begin
    state         <= state_n;
    flush_cnt     <= flush_cnt_n;
    wait_cnt      <= (clr | ~busy) ? 16'd0 : wait_inc;
    o_mem_timeout <= clr ? 1'b0 : o_mem_timeout | (busy & (wait_inc >= 16'(MEM_TIMEOUT)));
  end
`ifdef HAZ_PERF_CNT_EN
  sat_counter #(.WIDTH(CNT_W)) u_cnt_load  (.clk(clk), .clr(clr), .inc(ld),            .count(o_cnt_load));
  sat_counter #(.WIDTH(CNT_W)) u_cnt_flush (.clk(clk), .clr(clr), .inc(br),            .count(o_cnt_flush));
  sat_counter #(.WIDTH(CNT_W)) u_cnt_mem   (.clk(clk), .clr(clr), .inc(stall_all),     .count(o_cnt_mem));
`else
  assign o_cnt_load  = '0;
  assign o_cnt_flush = '0;
  assign o_cnt_mem   = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (FLUSH_CYCLES=1, MEM_TIMEOUT=4)
module tb_hazard_ctrl;
  localparam int CW = 32;
`ifdef HAZ_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif
  typedef struct packed {
    logic [1:0]    st;
    logic [3:0]    stl;
    logic          idc;
    logic          exc;
    logic          rd;
    logic          to;
    logic [CW-1:0] cl;
    logic [CW-1:0] cf;
    logic [CW-1:0] cm;
  } exp_t;

  logic clk = 0, clr = 0, hz = 0, br = 0, rq = 0, ak = 0;
  logic if_s, id_s, ex_s, me_s, idc, exc, rd, to;
  logic [1:0] st;
  logic [CW-1:0] cl, cf, cm;
  exp_t exp_q[$];
  string nm_q[$];
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .i_id_mem_hazard(hz), .i_ex_branch_taken(br),
    .i_me_req(rq), .i_me_ack(ak), .o_if_stall(if_s), .o_id_stall(id_s),
    .o_ex_stall(ex_s), .o_me_stall(me_s), .o_id_clr(idc), .o_ex_clr(exc),
    .o_pc_redirect(rd), .o_mem_timeout(to), .o_state(st),
    .o_cnt_load(cl), .o_cnt_flush(cf), .o_cnt_mem(cm)
  );

  function automatic exp_t ev(logic [1:0] s, logic [3:0] stl, logic i, logic e, logic r, logic t,
                              int nl, int nf, int nm);
    exp_t x;
    x.st = s; x.stl = stl; x.idc = i; x.exc = e; x.rd = r; x.to = t;
    x.cl = CW'(nl * PERF); x.cf = CW'(nf * PERF); x.cm = CW'(nm * PERF);
    return x;
  endfunction

  task automatic step(input string n, input logic c, input logic h, input logic b, input logic q,
                      input logic a, input bit chk, input exp_t e);
    @(posedge clk);
    #1;
    clr = c; hz = h; br = b; rq = q; ak = a;
    if (chk) begin
      exp_q.push_back(e);
      nm_q.push_back(n);
    end
  endtask

  // monitor: outputs are stable mid-cycle, compare against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, g;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      g = '{st, {if_s, id_s, ex_s, me_s}, idc, exc, rd, to, cl, cf, cm};
      total++;
      if (g !== e) $display("FAIL %s got %h exp %h", n, g, e);
      else passed++;
    end
  end

  initial begin
    exp_t z;
    z = '0;
    //        name          clr hz br rq ak chk      st  stl    idc exc rd to  cl cf cm
    step("rst0",      1, 0, 0, 0, 0, 0, z);
    step("rst1",      1, 0, 0, 0, 0, 1, ev(0, 4'b0000, 1, 1, 0, 0, 0, 0, 0));
    step("idle0",     0, 0, 0, 0, 0, 1, ev(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    step("loaduse",   0, 1, 0, 0, 0, 1, ev(0, 4'b1100, 0, 1, 0, 0, 0, 0, 0));
    step("post_ld",   0, 0, 0, 0, 0, 1, ev(0, 4'b0000, 0, 0, 0, 0, 1, 0, 0));
    step("branch",    0, 0, 1, 0, 0, 1, ev(0, 4'b0000, 1, 1, 1, 0, 1, 0, 0));
    step("flush_hz",  0, 1, 0, 0, 0, 1, ev(2, 4'b0000, 1, 0, 0, 0, 1, 1, 0));
    step("post_fl",   0, 0, 0, 0, 0, 1, ev(0, 4'b0000, 0, 0, 0, 0, 1, 1, 0));
    step("mw_br0",    0, 0, 1, 1, 0, 1, ev(0, 4'b1111, 0, 0, 0, 0, 1, 1, 0));
    step("mw_br1",    0, 0, 1, 1, 0, 1, ev(1, 4'b1111, 0, 0, 0, 0, 1, 1, 1));
    step("mw_br2",    0, 0, 1, 1, 0, 1, ev(1, 4'b1111, 0, 0, 0, 0, 1, 1, 2));
    step("mw_ack_br", 0, 0, 1, 1, 1, 1, ev(1, 4'b0000, 1, 1, 1, 0, 1, 1, 3));
    step("mw_flush",  0, 0, 0, 0, 0, 1, ev(2, 4'b0000, 1, 0, 0, 0, 1, 2, 3));
    step("mw_run",    0, 0, 0, 0, 0, 1, ev(0, 4'b0000, 0, 0, 0, 0, 1, 2, 3));
    step("to_b1",     0, 0, 0, 1, 0, 1, ev(0, 4'b1111, 0, 0, 0, 0, 1, 2, 3));
    step("to_b2",     0, 0, 0, 1, 0, 1, ev(1, 4'b1111, 0, 0, 0, 0, 1, 2, 4));
    step("to_b3",     0, 0, 0, 1, 0, 1, ev(1, 4'b1111, 0, 0, 0, 0, 1, 2, 5));
    step("to_b4",     0, 0, 0, 1, 0, 1, ev(1, 4'b1111, 0, 0, 0, 0, 1, 2, 6));
    step("to_b5",     0, 0, 0, 1, 0, 1, ev(1, 4'b1111, 0, 0, 0, 1, 1, 2, 7));
    step("to_b6",     0, 0, 0, 1, 0, 1, ev(1, 4'b1111, 0, 0, 0, 1, 1, 2, 8));
    step("to_drop",   0, 0, 0, 0, 0, 1, ev(1, 4'b0000, 0, 0, 0, 1, 1, 2, 9));
    step("to_sticky", 0, 0, 0, 0, 0, 1, ev(0, 4'b0000, 0, 0, 0, 1, 1, 2, 9));
    step("clr_prio",  1, 1, 0, 1, 0, 1, ev(0, 4'b0000, 1, 1, 0, 1, 1, 2, 9));
    step("clr_done",  0, 0, 0, 0, 0, 1, ev(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    step("br2",       0, 0, 1, 0, 0, 1, ev(0, 4'b0000, 1, 1, 1, 0, 0, 0, 0));
    step("fl_busy",   0, 0, 0, 1, 0, 1, ev(2, 4'b1111, 0, 0, 0, 0, 0, 1, 0));
    step("fl_ack",    0, 1, 0, 1, 1, 1, ev(1, 4'b0000, 0, 0, 0, 0, 0, 1, 1));
    step("fl_resume", 0, 0, 0, 0, 0, 1, ev(2, 4'b0000, 1, 0, 0, 0, 0, 1, 1));
    step("fl_end",    0, 0, 0, 0, 0, 1, ev(0, 4'b0000, 0, 0, 0, 0, 0, 1, 1));
    step("ld_a",      0, 1, 0, 0, 0, 1, ev(0, 4'b1100, 0, 1, 0, 0, 0, 1, 1));
    step("ld_b",      0, 1, 0, 0, 0, 1, ev(0, 4'b1100, 0, 1, 0, 0, 1, 1, 1));
    step("ld_end",    0, 0, 0, 0, 0, 1, ev(0, 4'b0000, 0, 0, 0, 0, 2, 1, 1));
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) $display("FAIL drain got %0d pending exp 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
